emu_clock_ctrl: RTL and testbench

//  Run-control stage that consumes the free-running emulation clock and

---
 rtl/emu_clock_ctrl.sv | 124 ++++++++++++
 tb/tb_emu_clock_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_clock_ctrl.sv
// ---------------------------------------------------------------------------
// emu_clock_ctrl : run-control FSM producing the model tick enable (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module emu_clock_ctrl #(
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned STEP_WIDTH = 32,
  parameter int unsigned PAUSE_SRC  = 4
) (
  input  logic                  clock_i,
  input  logic                  resetn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [STEP_WIDTH-1:0] cmd_steps_i,
  input  logic                  abort_i,
  input  logic [PAUSE_SRC-1:0]  pause_req_i,
  output logic                  tick_o,
  output logic                  running_o,
  output logic [STEP_WIDTH-1:0] steps_left_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o,
  output logic                  done_pulse_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  done_q, done_d;
  logic                  running_q;

  logic                  active_w;
  logic                  tick_w;
  logic                  ready_w;
  logic                  accept_w;

  // tick is purely combinational so a pause or abort stalls the model in the
  // very cycle it is raised.
  assign active_w = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign tick_w   = active_w && !(|pause_req_i) && !abort_i;
  assign ready_w  = (state_q != ST_STEP);
  assign accept_w = cmd_valid_i && ready_w;

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
      steps_d = '0;
    end else begin
      if (tick_w) begin
        count_d = count_q + CNT_WIDTH'(1);
        if (state_q == ST_STEP) begin
          steps_d = steps_q - STEP_WIDTH'(1);
          if (steps_q == STEP_WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      // Commands are only accepted outside STEP, so they never collide with
      // the step-completion path above.
      if (accept_w) begin
        case (cmd_op_i)
          OP_STOP: state_d = ST_IDLE;
          OP_RUN:  state_d = ST_RUN;
          OP_STEP: begin
            if (cmd_steps_i != '0) begin
              state_d = ST_STEP;
              steps_d = cmd_steps_i;
            end else begin
              state_d = ST_IDLE;
              steps_d = '0;
              done_d  = 1'b1;
            end
          end
          OP_CLEAR: count_d = '0;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= ST_IDLE;
      steps_q   <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      count_q   <= count_d;
      done_q    <= done_d;
      running_q <= active_w;
    end
  end

  assign tick_o        = tick_w;
  assign cmd_ready_o   = ready_w;
  assign running_o     = running_q;
  assign steps_left_o  = steps_q;
  assign cycle_count_o = count_q;
  assign done_pulse_o  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_emu_clock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_emu_clock_ctrl : directed self-checking bench for emu_clock_ctrl (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_emu_clock_ctrl;

  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_steps;
  logic        abort;
  logic [3:0]  pause_req;
  logic        tick;
  logic        running;
  logic [31:0] steps_left;
  logic [63:0] cycle_count;
  logic        done_pulse;

  logic        v8;
  logic        ready8;
  logic [1:0]  op8;
  logic [15:0] steps_in8;
  logic        abort8;
  logic [3:0]  pause8;
  logic        tick8;
  logic        running8;
  logic [15:0] steps8;
  logic [7:0]  cnt8;
  logic        done8;

  int checks = 0;
  int errors = 0;

  int t2_steps[7] = '{4, 3, 2, 2, 2, 2, 1};
  int t2_tick[7]  = '{1, 1, 0, 0, 0, 1, 1};
  int t2_cnt[7]   = '{0, 1, 2, 2, 2, 2, 3};

  emu_clock_ctrl #(.CNT_WIDTH(64), .STEP_WIDTH(32), .PAUSE_SRC(4)) u_dut (
    .clock_i       (clk),
    .resetn_i      (resetn),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_steps_i   (cmd_steps),
    .abort_i       (abort),
    .pause_req_i   (pause_req),
    .tick_o        (tick),
    .running_o     (running),
    .steps_left_o  (steps_left),
    .cycle_count_o (cycle_count),
    .done_pulse_o  (done_pulse)
  );

  emu_clock_ctrl #(.CNT_WIDTH(8), .STEP_WIDTH(16), .PAUSE_SRC(4)) u_dut8 (
    .clock_i       (clk),
    .resetn_i      (resetn),
    .cmd_valid_i   (v8),
    .cmd_ready_o   (ready8),
    .cmd_op_i      (op8),
    .cmd_steps_i   (steps_in8),
    .abort_i       (abort8),
    .pause_req_i   (pause8),
    .tick_o        (tick8),
    .running_o     (running8),
    .steps_left_o  (steps8),
    .cycle_count_o (cnt8),
    .done_pulse_o  (done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = OP_STOP; cmd_steps = '0;
    abort = 1'b0; pause_req = '0;
    v8 = 1'b0; op8 = OP_STOP; steps_in8 = '0; abort8 = 1'b0; pause8 = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_tick", tick, 0);
    chk("rst_running", running, 0);
    chk("rst_steps", steps_left, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_ready", cmd_ready, 1);
    @(negedge clk); resetn = 1'b1;

    // 1: STEP 5 without pauses
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_steps = 32'd5; #1;
    chk("t1_ready_idle", cmd_ready, 1);
    chk("t1_tick_idle", tick, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); cmd_valid = 1'b0; #1;
      chk("t1_tick", tick, 1);
      chk("t1_steps", steps_left, 64'(6 - i));
      chk("t1_count", cycle_count, 64'(i - 1));
      chk("t1_ready_step", cmd_ready, 0);
      chk("t1_running", running, (i > 1));
      chk("t1_done_early", done_pulse, 0);
    end
    @(negedge clk); #1;
    chk("t1_tick_after", tick, 0);
    chk("t1_done", done_pulse, 1);
    chk("t1_steps_end", steps_left, 0);
    chk("t1_count_end", cycle_count, 5);
    chk("t1_running_lag", running, 1);
    chk("t1_ready_end", cmd_ready, 1);
    @(negedge clk); #1;
    chk("t1_done_once", done_pulse, 0);
    chk("t1_running_off", running, 0);

    // 2: STEP 4 with a 3-cycle pause after the second tick
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_CLEAR; #1;
    @(negedge clk); cmd_op = OP_STEP; cmd_steps = 32'd4; #1;
    chk("t2_cleared", cycle_count, 0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      pause_req = (c >= 2 && c <= 4) ? 4'b0010 : 4'b0000;
      #1;
      chk("t2_tick", tick, 64'(t2_tick[c]));
      chk("t2_steps", steps_left, 64'(t2_steps[c]));
      chk("t2_count", cycle_count, 64'(t2_cnt[c]));
    end
    @(negedge clk); pause_req = '0; #1;
    chk("t2_done", done_pulse, 1);
    chk("t2_count_end", cycle_count, 4);
    chk("t2_steps_end", steps_left, 0);
    chk("t2_tick_end", tick, 0);

    // 3: RUN for 10 ticks then STOP
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_CLEAR; #1;
    @(negedge clk); cmd_op = OP_RUN; #1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      cmd_valid = (i == 10);
      cmd_op    = OP_STOP;
      #1;
      chk("t3_tick", tick, 1);
      chk("t3_ready", cmd_ready, 1);
      chk("t3_count", cycle_count, 64'(i - 1));
      chk("t3_running", running, (i > 1));
    end
    @(negedge clk); cmd_valid = 1'b0; #1;
    chk("t3_tick_stop", tick, 0);
    chk("t3_count_end", cycle_count, 10);
    chk("t3_running_lag", running, 1);
    chk("t3_ready_end", cmd_ready, 1);
    @(negedge clk); #1;
    chk("t3_running_off", running, 0);

    // 4: CLEAR on a tick cycle wins over the increment
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_RUN; #1;
    @(negedge clk); cmd_valid = 1'b0; #1;
    chk("t4_tick", tick, 1);
    chk("t4_count_a", cycle_count, 10);
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_CLEAR; #1;
    chk("t4_ready_clear", cmd_ready, 1);
    chk("t4_count_b", cycle_count, 11);
    @(negedge clk); cmd_valid = 1'b0; #1;
    chk("t4_count_clr", cycle_count, 0);
    chk("t4_tick_clr", tick, 1);
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_STOP; #1;
    chk("t4_count_one", cycle_count, 1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    chk("t4_count_stop", cycle_count, 2);
    chk("t4_tick_stop", tick, 0);

    // 4b: 8-bit counter wraps after 256 ticks
    @(negedge clk); v8 = 1'b1; op8 = OP_RUN; #1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk); v8 = 1'b0; #1;
      if (k == 256) begin
        chk("t4w_count_max", cnt8, 8'hFF);
        chk("t4w_tick", tick8, 1);
      end
    end
    @(negedge clk); v8 = 1'b1; op8 = OP_STOP; #1;
    chk("t4w_wrap", cnt8, 0);
    @(negedge clk); v8 = 1'b0; #1;
    chk("t4w_after_wrap", cnt8, 1);
    chk("t4w_tick_stop", tick8, 0);
    chk("t4w_steps", steps8, 0);
    chk("t4w_done", done8, 0);
    @(negedge clk); #1;
    chk("t4w_running_off", running8, 0);
    chk("t4w_ready", ready8, 1);

    // 5: STEP 100 aborted after 37 ticks
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_CLEAR; #1;
    @(negedge clk); cmd_op = OP_STEP; cmd_steps = 32'd100; #1;
    for (int i = 1; i <= 37; i++) begin
      @(negedge clk); cmd_valid = 1'b0; #1;
      chk("t5_tick", tick, 1);
    end
    @(negedge clk); abort = 1'b1; #1;
    chk("t5_tick_abort", tick, 0);
    chk("t5_count_abort", cycle_count, 37);
    chk("t5_steps_abort", steps_left, 63);
    @(negedge clk); abort = 1'b0; #1;
    chk("t5_steps_zero", steps_left, 0);
    chk("t5_no_done", done_pulse, 0);
    chk("t5_count_end", cycle_count, 37);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_tick_idle", tick, 0);
    @(negedge clk); #1;
    chk("t5_no_done_late", done_pulse, 0);
    chk("t5_running_off", running, 0);
    // abort beats an accepted RUN in the same cycle
    @(negedge clk); abort = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RUN; #1;
    @(negedge clk); abort = 1'b0; cmd_valid = 1'b0; #1;
    chk("t5_prio_tick", tick, 0);
    chk("t5_prio_count", cycle_count, 37);
    // STEP 0 gives a done pulse and no ticks
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_steps = 32'd0; #1;
    chk("t5_prio_running", running, 0);
    @(negedge clk); cmd_valid = 1'b0; #1;
    chk("t5_step0_done", done_pulse, 1);
    chk("t5_step0_tick", tick, 0);
    chk("t5_step0_steps", steps_left, 0);
    chk("t5_step0_count", cycle_count, 37);
    chk("t5_step0_running", running, 0);
    @(negedge clk); #1;
    chk("t5_step0_once", done_pulse, 0);
    chk("t5_step0_tick2", tick, 0);

    // 6: STEP 50, command ignored while stepping, async reset mid-step
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_steps = 32'd50; #1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); cmd_valid = 1'b0; #1;
      chk("t6_tick", tick, 1);
      chk("t6_steps", steps_left, 64'(51 - i));
    end
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_RUN; #1;
    chk("t6_ready_step", cmd_ready, 0);
    chk("t6_steps_4", steps_left, 47);
    @(negedge clk); cmd_valid = 1'b0; #1;
    chk("t6_steps_5", steps_left, 46);
    @(negedge clk); #1;
    chk("t6_steps_6", steps_left, 45);
    chk("t6_tick_6", tick, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_running", running, 0);
    chk("t6_rst_steps", steps_left, 0);
    chk("t6_rst_count", cycle_count, 0);
    chk("t6_rst_done", done_pulse, 0);
    chk("t6_rst_ready", cmd_ready, 1);
    @(negedge clk); resetn = 1'b1; #1;
    chk("t6_rel_ready", cmd_ready, 1);
    chk("t6_rel_tick", tick, 0);
    @(negedge clk); #1;
    chk("t6_idle_tick", tick, 0);
    chk("t6_idle_running", running, 0);
    chk("t6_idle_done", done_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
